// File: rtl/time_set_editor.sv
// time_set_editor: debounced five-button editor that lets the user adjust
// hour/minute/second and load the edited time back into the running clock.
module time_set_editor #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BLINK_CYCLES    = 25000000,
  parameter int TIMEOUT_CYCLES  = 1000000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        up,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        middle,
  input  logic [10:0] cur_hour,
  input  logic [10:0] cur_minute,
  input  logic [10:0] cur_second,
  output logic        edit_active,
  output logic [1:0]  cursor,
  output logic [10:0] set_hour,
  output logic [10:0] set_minute,
  output logic [10:0] set_second,
  output logic        load,
  output logic        blink
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {S_IDLE, S_EDIT} state_t;
  state_t r_state, w_next;
  logic [4:0] w_raw, r_s1, r_s2, w_db, r_db_q, w_evt;
  logic w_mid, w_up, w_dn, w_lf, w_rt, w_any;
  logic [10:0] r_hour, r_min, r_sec, w_hour_n, w_min_n, w_sec_n, w_sel, w_max, w_fld;
  logic [1:0] r_cur, w_cur_n;
  logic r_load, w_load_n, r_blink, w_blink_n;
  logic [BW-1:0] r_bcnt, w_bcnt_n;
  logic [TW-1:0] r_to, w_to_n;
  assign w_raw = {middle, up, down, left, right};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_db_q <= '0;
    end else begin
      r_s1   <= w_raw;
      r_s2   <= r_s1;
      r_db_q <= w_db;
    end
  end
  for (genvar i = 0; i < 5; i++) begin : g_db
    logic [DW-1:0] r_cnt;
    logic          r_lvl;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_s2[i] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        r_cnt <= '0;
        r_lvl <= r_s2[i];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
    assign w_db[i] = r_lvl;
  end
  // Only the highest-priority press in a cycle is acted on.
  assign w_evt = w_db & ~r_db_q;
  assign w_any = |w_evt;
  assign w_mid = w_evt[4];
  assign w_up  = w_evt[3] & ~w_evt[4];
  assign w_dn  = w_evt[2] & ~|w_evt[4:3];
  assign w_lf  = w_evt[1] & ~|w_evt[4:2];
  assign w_rt  = w_evt[0] & ~|w_evt[4:1];
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    if (r_state == S_IDLE) begin
      if (w_mid) w_next = S_EDIT;
    end else if (w_mid || (!w_any && r_to == TW'(TIMEOUT_CYCLES - 1))) begin
      w_next = S_IDLE;
    end
  end
  always_comb begin
    w_sel     = r_cur == 2'd2 ? r_hour : r_cur == 2'd1 ? r_min : r_sec;
    w_max     = r_cur == 2'd2 ? 11'd23 : 11'd59;
    w_fld     = w_up ? (w_sel == w_max ? 11'd0 : w_sel + 11'd1) : (w_sel == 11'd0 ? w_max : w_sel - 11'd1);
    w_hour_n  = r_hour;
    w_min_n   = r_min;
    w_sec_n   = r_sec;
    w_cur_n   = r_cur;
    w_load_n  = 1'b0;
    w_blink_n = r_blink;
    w_bcnt_n  = r_bcnt;
    w_to_n    = '0;
    if (r_state == S_IDLE) begin
      if (w_mid) begin
        w_hour_n  = cur_hour > 11'd23 ? 11'd0 : cur_hour;
        w_min_n   = cur_minute > 11'd59 ? 11'd0 : cur_minute;
        w_sec_n   = cur_second > 11'd59 ? 11'd0 : cur_second;
        w_cur_n   = 2'd2;
        w_blink_n = 1'b1;
        w_bcnt_n  = '0;
      end
    end else begin
      w_to_n    = w_any ? '0 : r_to + 1'b1;
      w_load_n  = w_mid;
      w_blink_n = r_bcnt == BW'(BLINK_CYCLES - 1) ? ~r_blink : r_blink;
      w_bcnt_n  = r_bcnt == BW'(BLINK_CYCLES - 1) ? '0 : r_bcnt + 1'b1;
      w_cur_n   = w_lf ? (r_cur == 2'd2 ? 2'd0 : r_cur + 2'd1) :
                  w_rt ? (r_cur == 2'd0 ? 2'd2 : r_cur - 2'd1) : r_cur;
      if (w_up || w_dn) begin
        w_blink_n = 1'b1;
        w_bcnt_n  = '0;
        w_hour_n  = r_cur == 2'd2 ? w_fld : r_hour;
        w_min_n   = r_cur == 2'd1 ? w_fld : r_min;
        w_sec_n   = r_cur == 2'd0 ? w_fld : r_sec;
      end
    end
    if (w_next == S_IDLE) begin
      w_blink_n = 1'b0;
      w_bcnt_n  = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hour  <= '0;
      r_min   <= '0;
      r_sec   <= '0;
      r_cur   <= '0;
      r_load  <= 1'b0;
      r_blink <= 1'b0;
      r_bcnt  <= '0;
      r_to    <= '0;
    end else begin
      r_hour  <= w_hour_n;
      r_min   <= w_min_n;
      r_sec   <= w_sec_n;
      r_cur   <= w_cur_n;
      r_load  <= w_load_n;
      r_blink <= w_blink_n;
      r_bcnt  <= w_bcnt_n;
      r_to    <= w_to_n;
    end
  end
  assign edit_active = r_state == S_EDIT;
  assign cursor      = r_cur;
  assign set_hour    = r_hour;
  assign set_minute  = r_min;
  assign set_second  = r_sec;
  assign load        = r_load;
  assign blink       = r_blink;
endmodule
